// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use stalls, multicycle EX waits and taken-branch flushes.
// Define HAZ_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module hazard_stall_ctrl #(
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_mc_start,
    input  logic       mc_done,
    input  logic       br_taken_ex,
    output logic       pc_hold,
    output logic       ifid_hold,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       ex_hold,
    output logic       mc_busy,
    output logic       mc_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    // The counter is shared by both stall states, so it must also reach LOAD_LAT-1 (up to 6).
    localparam int unsigned MC_W  = $clog2(MC_TIMEOUT + 1);
    localparam int unsigned CNT_W = (MC_W > 3) ? MC_W : 3;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LOAD_END = cnt_t'(LOAD_LAT - 1);
    localparam cnt_t MC_END   = cnt_t'(MC_TIMEOUT);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD_STALL,
        ST_MC_WAIT
    } state_e;

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   mc_err_q, mc_err_d;
    logic   lu_hit;
    logic   mc_stall;

    assign lu_hit = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    assign mc_stall = ex_mc_start && !mc_done;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            mc_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_err_q <= mc_err_d;
        end
    end

    // NOTE: every combinational output is given a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_err_d = mc_err_q;
        unique case (state_q)
            ST_RUN: begin
                if (br_taken_ex) begin
                    state_d = ST_RUN;
                end else if (mc_stall) begin
                    state_d = ST_MC_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (ex_mc_start) begin
                    state_d = ST_RUN;
                end else if (lu_hit && (LOAD_LAT > 1)) begin
                    state_d = ST_LOAD_STALL;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_LOAD_STALL: begin
                if (cnt_q == LOAD_END) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_MC_WAIT: begin
                if (mc_done) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == MC_END) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    mc_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes act in the same cycle as the hazard; they are forced low while reset is held.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        ex_hold     = 1'b0;
        mc_busy     = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ST_RUN: begin
                    if (br_taken_ex) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (mc_stall) begin
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                        ex_hold   = 1'b1;
                    end else if (!ex_mc_start && lu_hit) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                ST_LOAD_STALL: begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end
                ST_MC_WAIT: begin
                    mc_busy = 1'b1;
                    // On the done or timeout cycle EX is released so the result can advance.
                    if (!mc_done && (cnt_q != MC_END)) begin
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                        ex_hold   = 1'b1;
                    end
                end
                default: begin
                    pc_hold = 1'b0;
                end
            endcase
        end
    end

    assign mc_err = mc_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3, MC_TIMEOUT=4)
// share one input stream; expected strobe vectors are queued at drive time and compared at negedge.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_mc_start, mc_done, br_taken_ex;

    logic [2:0] pc_hold, ifid_hold, idex_bubble, ifid_flush, ex_hold, mc_busy, mc_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt [3];
    logic [15:0] flush_cnt [3];
`endif

    // Packed observation order: {pc_hold, ifid_hold, idex_bubble, ifid_flush, ex_hold, mc_busy, mc_err}
    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] LU  = 7'b1110000;
    localparam logic [6:0] FL  = 7'b0011000;
    localparam logic [6:0] MCH = 7'b1100100;
    localparam logic [6:0] MCW = 7'b1100110;
    localparam logic [6:0] BSY = 7'b0000010;
    localparam logic [6:0] ERR = 7'b0000001;

    hazard_stall_ctrl #(.LOAD_LAT(1), .MC_TIMEOUT(64)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .br_taken_ex(br_taken_ex), .pc_hold(pc_hold[0]), .ifid_hold(ifid_hold[0]),
        .idex_bubble(idex_bubble[0]), .ifid_flush(ifid_flush[0]), .ex_hold(ex_hold[0]),
        .mc_busy(mc_busy[0]), .mc_err(mc_err[0])
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
`endif
    );

    hazard_stall_ctrl #(.LOAD_LAT(3), .MC_TIMEOUT(64)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .br_taken_ex(br_taken_ex), .pc_hold(pc_hold[1]), .ifid_hold(ifid_hold[1]),
        .idex_bubble(idex_bubble[1]), .ifid_flush(ifid_flush[1]), .ex_hold(ex_hold[1]),
        .mc_busy(mc_busy[1]), .mc_err(mc_err[1])
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
`endif
    );

    hazard_stall_ctrl #(.LOAD_LAT(1), .MC_TIMEOUT(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .br_taken_ex(br_taken_ex), .pc_hold(pc_hold[2]), .ifid_hold(ifid_hold[2]),
        .idex_bubble(idex_bubble[2]), .ifid_flush(ifid_flush[2]), .ex_hold(ex_hold[2]),
        .mc_busy(mc_busy[2]), .mc_err(mc_err[2])
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt[2]), .flush_cnt(flush_cnt[2])
`endif
    );

    typedef struct {
        string      tag;
        logic [6:0] exp_a;
        logic [6:0] exp_b;
        logic [6:0] exp_c;
    } exp_t;

    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
`ifdef HAZ_PERF_CNT_EN
    int   exp_stall_a = 0;
    int   exp_flush_a = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] obs(input int i);
        return {pc_hold[i], ifid_hold[i], idex_bubble[i], ifid_flush[i],
                ex_hold[i], mc_busy[i], mc_err[i]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "/a"}, 32'(obs(0)), 32'(e.exp_a));
            check({e.tag, "/b"}, 32'(obs(1)), 32'(e.exp_b));
            check({e.tag, "/c"}, 32'(obs(2)), 32'(e.exp_c));
`ifdef HAZ_PERF_CNT_EN
            if (!rst_n) begin
                exp_stall_a = 0;
                exp_flush_a = 0;
            end else begin
                exp_stall_a += int'(e.exp_a[6]);
                exp_flush_a += int'(e.exp_a[3]);
            end
`endif
        end
    end

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic u1, input logic [4:0] rs2, input logic u2,
                          input logic start, input logic done, input logic br);
        ex_memread  = mr;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_use_rs1  = u1;
        id_rs2      = rs2;
        id_use_rs2  = u2;
        ex_mc_start = start;
        mc_done     = done;
        br_taken_ex = br;
    endtask

    task automatic quiet();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expected vectors for the inputs just driven, then advance to the next post-edge slot.
    task automatic cyc(input string tag, input logic [6:0] ea, input logic [6:0] eb,
                       input logic [6:0] ec);
        exp_t e;
        e.tag   = tag;
        e.exp_a = ea;
        e.exp_b = eb;
        e.exp_c = ec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        quiet();
        @(posedge clk);
        #1;
        cyc("reset", Z, Z, Z);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("reset_br", Z, Z, Z);
        rst_n = 1'b1;
        quiet();
        cyc("idle", Z, Z, Z);

        // Load-use on rs1; branch during the LOAD_LAT=3 tail is ignored there.
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs1", LU, LU, LU);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_tail_br", FL, LU, FL);
        quiet();
        cyc("lu_tail", Z, LU, Z);
        cyc("lu_end", Z, Z, Z);

        set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rd_zero", Z, Z, Z);
        set_in(1'b1, 5'd5, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("no_use", Z, Z, Z);
        set_in(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("no_load", Z, Z, Z);

        set_in(1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs2", LU, LU, LU);
        quiet();
        cyc("lu_rs2_t1", Z, LU, Z);
        cyc("lu_rs2_t2", Z, LU, Z);
        cyc("lu_rs2_end", Z, Z, Z);

        // Branch outranks load-use and multicycle start; neither leaves RUN.
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("br_lu", FL, FL, FL);
        quiet();
        cyc("br_lu_after", Z, Z, Z);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("br_mc", FL, FL, FL);
        quiet();
        cyc("br_mc_after", Z, Z, Z);

        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("mc_zero", Z, Z, Z);
        set_in(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("mc_zero_lu", Z, Z, Z);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("stray_done", Z, Z, Z);

        // Multicycle op: done after 5 wait cycles; the MC_TIMEOUT=4 instance times out first.
        set_in(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mc_start", MCH, MCH, MCH);
        quiet();
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("mc_wait%0d", i), MCW, MCW, (i < 3) ? MCW : ((i == 3) ? BSY : ERR));
        end
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("mc_done", BSY, BSY, ERR);
        quiet();
        cyc("mc_after", Z, Z, ERR);
        cyc("err_sticky", Z, Z, ERR);

        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mc_start2", MCH, MCH, MCH | ERR);
        quiet();
        cyc("mc_wait2", MCW, MCW, MCW | ERR);
`ifdef HAZ_PERF_CNT_EN
        check("stall_cnt", stall_cnt[0], 32'(exp_stall_a));
        check("flush_cnt", 32'(flush_cnt[0]), 32'(exp_flush_a));
`endif

        // Asynchronous reset in the middle of MC_WAIT clears everything at once.
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("rst_mid", Z, Z, Z);
        rst_n = 1'b1;
        quiet();
        cyc("post_rst", Z, Z, Z);
        cyc("post_rst2", Z, Z, Z);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
